// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Collects instruction bytes from the UART receiver (high byte
//                first), assembles them into instruction words and writes one
//                word per address into the program memory, starting at 0.
//                A load ends on the HALT word (which is itself written) or
//                when the last address has been written (overflow).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    start       in   single-cycle pulse, begins a load (IDLE/DONE only)
//    rx_data     in   received byte, qualified by rx_valid
//    rx_valid    in   single-cycle byte strobe
//    mem_addr    out  program memory write address
//    mem_data    out  program memory write data
//    mem_we      out  write enable, one cycle per word
//    busy        out  load in progress
//    done        out  load complete (held until next accepted start)
//    overflow    out  load ended on a full address space, not on HALT
//    word_count  out  words written in the current or last load
// ============================================================================
module program_loader #(
    parameter int                    ADDR_LENGTH = 11,
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_data,
    output logic                   mem_we,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [ADDR_LENGTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [7:0]             high_byte, high_byte_next;
    logic [ADDR_LENGTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0]  data_next;
    logic                   we_next;
    logic                   busy_next;
    logic                   done_next;
    logic                   overflow_next;
    logic [ADDR_LENGTH:0]   count_next;

    // mem_data doubles as the assembled-word register; it is only updated on
    // entry to WRITE, so it stays stable for the whole write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            high_byte  <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_next;
            high_byte  <= high_byte_next;
            mem_addr   <= addr_next;
            mem_data   <= data_next;
            mem_we     <= we_next;
            busy       <= busy_next;
            done       <= done_next;
            overflow   <= overflow_next;
            word_count <= count_next;
        end
    end

    always_comb begin
        state_next     = state;
        high_byte_next = high_byte;
        addr_next      = mem_addr;
        data_next      = mem_data;
        we_next        = 1'b0;
        busy_next      = busy;
        done_next      = done;
        overflow_next  = overflow;
        count_next     = word_count;

        case (state)
            S_IDLE, S_DONE: begin
                // start wins over a coincident byte, which is simply dropped
                if (start) begin
                    state_next    = S_HIGH;
                    addr_next     = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    busy_next     = 1'b1;
                    done_next     = 1'b0;
                end
            end
            S_HIGH: begin
                if (rx_valid) begin
                    high_byte_next = rx_data;
                    state_next     = S_LOW;
                end
            end
            S_LOW: begin
                if (rx_valid) begin
                    data_next  = DATA_WIDTH'({high_byte, rx_data});
                    we_next    = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                count_next = word_count + (ADDR_LENGTH + 1)'(1);
                if (mem_data == HALT_WORD) begin
                    state_next = S_DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else if (&mem_addr) begin
                    // last address just written: stop before the address wraps
                    state_next    = S_DONE;
                    busy_next     = 1'b0;
                    done_next     = 1'b1;
                    overflow_next = 1'b1;
                end else begin
                    state_next = S_HIGH;
                    addr_next  = mem_addr + ADDR_LENGTH'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_program_loader
//  Description : Scoreboard bench for program_loader (ADDR_LENGTH = 3).
//                A byte-level reference model predicts every memory write;
//                a negedge monitor pops and compares each mem_we cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   word_count;

    program_loader #(
        .ADDR_LENGTH (AW),
        .DATA_WIDTH  (DW),
        .HALT_WORD   (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int when;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_seen  = 0;

    // Reference model: a load is a sequence of bytes paired into words
    bit         m_active = 0;
    bit         m_pend   = 0;
    bit         m_ovf    = 0;
    int         m_addr   = 0;
    int         m_count  = 0;
    logic [7:0] m_hi     = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_start();
        if (!m_active) begin
            m_active = 1;
            m_pend   = 0;
            m_ovf    = 0;
            m_addr   = 0;
            m_count  = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int when);
        exp_t e;
        int   w;
        if (!m_active) return;
        if (!m_pend) begin
            m_hi   = b;
            m_pend = 1;
        end else begin
            w      = {16'h0000, m_hi, b};
            e.addr = m_addr;
            e.data = w;
            e.when = when;
            sbq.push_back(e);
            m_count++;
            m_pend = 0;
            if (w == 0) begin
                m_active = 0;
            end else if (m_addr == (1 << AW) - 1) begin
                m_active = 0;
                m_ovf    = 1;
            end else begin
                m_addr++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte strobe; the low byte of a word is expected on mem_we
    // in the cycle that follows the capturing edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b, cyc + 1);
        step();
        rx_valid = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        model_start();
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        check("done_rise", {31'd0, done}, 32'd1);
    endtask

    task automatic check_status();
        check("done",       {31'd0, done},     32'd1);
        check("busy",       {31'd0, busy},     32'd0);
        check("overflow",   {31'd0, overflow}, {31'd0, m_ovf});
        check("word_count", word_count,        m_count);
        check("sb_empty",   sbq.size(),        32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_addr",   mem_addr,   32'd0);
        check("rst_mem_data",   mem_data,   32'd0);
        check("rst_mem_we",     mem_we,     32'd0);
        check("rst_busy",       busy,       32'd0);
        check("rst_done",       done,       32'd0);
        check("rst_overflow",   overflow,   32'd0);
        check("rst_word_count", word_count, 32'd0);
    endtask

    // Monitor: every write the DUT presents must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_seen++;
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                         mem_addr, mem_data, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("wr_addr",    mem_addr, e.addr);
                check("wr_data",    mem_data, e.data);
                check("wr_latency", cyc,      e.when);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int gap;
        logic [15:0] w;

        // Reset state
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Bytes before start are dropped; then the basic load
        send_byte(8'hEE, 2);
        send_byte(8'h77, 3);
        check("pre_start_writes", wr_seen, 32'd0);
        wr_seen = 0;
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        send_word(16'h1234, 2);
        send_word(16'hABCD, 2);
        send_word(16'h0000, 2);
        wait_done();
        check_status();
        check("basic_we_pulses", wr_seen, 32'd3);

        // Reload after DONE
        step();
        wr_seen = 0;
        pulse_start();
        check("reload_done_clear", {31'd0, done}, 32'd0);
        send_word(16'h7F01, 3);
        send_word(16'h0000, 3);
        wait_done();
        check_status();
        check("reload_we_pulses", wr_seen, 32'd2);

        // Overflow: fill all eight addresses, then a ninth word is ignored
        step();
        wr_seen = 0;
        pulse_start();
        for (int i = 0; i < 8; i++) send_word(16'h0101 + 16'(i), 2);
        wait_done();
        check_status();
        send_word(16'h0909, 2);
        repeat (4) step();
        check("ovf_we_pulses", wr_seen, 32'd8);
        check("ovf_count_held", word_count, 32'd8);

        // start between high and low byte does not restart the load
        pulse_start();
        send_word(16'h4242, 2);
        send_byte(8'hA5, 2);
        pulse_start();
        send_byte(8'h5A, 2);
        send_word(16'h0000, 2);
        wait_done();
        check_status();

        // Reset mid-load after a high byte
        pulse_start();
        send_byte(8'h55, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        m_active = 0;
        m_pend   = 0;
        m_ovf    = 0;
        m_count  = 0;
        sbq.delete();
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        send_word(16'h1234, 2);
        send_word(16'h0000, 2);
        wait_done();
        check_status();

        // Randomized loads with stray bytes and variable byte spacing
        for (int l = 0; l < 8; l++) begin
            step();
            for (int s = 0; s < int'($urandom_range(0, 2)); s++)
                send_byte(8'($urandom), 2);
            pulse_start();
            nw = int'($urandom_range(1, 11));
            for (int i = 0; i < nw; i++) begin
                w   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
                gap = int'($urandom_range(2, 4));
                send_word(w, gap);
            end
            if (m_active) send_word(16'h0000, 2);
            wait_done();
            check_status();
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
